// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUFun codes, ALUFun group field, register-address width.
package alu_pkg;

  localparam int REG_AW = 5;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_LTZ   = 6'b111011;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;

  // The top two ALUFun bits pick the ALU unit.
  localparam int ALUFUN_GRP_HI = 5;
  localparam int ALUFUN_GRP_LO = 4;

  typedef enum logic [1:0] {
    GRP_ARITH = 2'b00,
    GRP_LOGIC = 2'b01,
    GRP_SHIFT = 2'b10,
    GRP_CMP   = 2'b11
  } alu_grp_e;

  function automatic alu_grp_e alufun_grp(input logic [5:0] fun);
    return alu_grp_e'(fun[ALUFUN_GRP_HI:ALUFUN_GRP_LO]);
  endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB; register 0 never forwards.
module ex_fwd_mux
  import alu_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          en,
  input  logic [AW-1:0] src,
  input  logic [31:0]   reg_data,
  input  logic          exm_wr,
  input  logic [AW-1:0] exm_rd,
  input  logic [31:0]   exm_data,
  input  logic          wb_wr,
  input  logic [AW-1:0] wb_rd,
  input  logic [31:0]   wb_data,
  output logic          hit,
  output logic [31:0]   data
);

  logic exm_hit;
  logic wb_hit;

  assign exm_hit = en && exm_wr && (exm_rd != '0) && (exm_rd == src);
  assign wb_hit  = en && wb_wr  && (wb_rd  != '0) && (wb_rd  == src);
  assign hit     = exm_hit || wb_hit;

  always_comb begin
    data = reg_data;
    if (exm_hit)     data = exm_data;
    else if (wb_hit) data = wb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the execute ALU, with valid/ready, stall and flush.
// Forwarding and stall-time operand refresh are built only when ID_EX_FORWARD_EN is defined.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int REG_AW = alu_pkg::REG_AW,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [5:0]        dec_alufun,
  input  logic              dec_sign,
  input  logic [31:0]       dec_rs_data,
  input  logic [31:0]       dec_rt_data,
  input  logic [31:0]       dec_imm,
  input  logic [4:0]        dec_shamt,
  input  logic              dec_alusrc,
  input  logic              dec_shamt_sel,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [PC_W-1:0]   dec_pc,
  input  logic              exm_wr,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [31:0]       exm_data,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [31:0]       wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [5:0]        alu_fun,
  output logic              alu_sign,
  output logic [REG_AW-1:0] out_rd,
  output logic [PC_W-1:0]   out_pc
);

  logic              valid_q, valid_d;
  logic [5:0]        fun_q, fun_d;
  logic              sign_q, sign_d;
  logic [31:0]       rs_data_q, rs_data_d;
  logic [31:0]       rt_data_q, rt_data_d;
  logic [31:0]       imm_q, imm_d;
  logic [4:0]        shamt_q, shamt_d;
  logic              alusrc_q, alusrc_d;
  logic              shamt_sel_q, shamt_sel_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [PC_W-1:0]   pc_q, pc_d;

  logic [31:0] fwd_rs, fwd_rt;

`ifdef ID_EX_FORWARD_EN
  logic rs_hit, rt_hit;

  ex_fwd_mux #(.AW(REG_AW)) u_fwd_rs (
    .en(!shamt_sel_q), .src(rs_q), .reg_data(rs_data_q),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .hit(rs_hit), .data(fwd_rs)
  );

  ex_fwd_mux #(.AW(REG_AW)) u_fwd_rt (
    .en(!alusrc_q), .src(rt_q), .reg_data(rt_data_q),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .hit(rt_hit), .data(fwd_rt)
  );
`else
  // Without forwarding the bypass buses and stored register numbers have no load.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exm_wr, exm_rd, exm_data, wb_wr, wb_rd, wb_data, rs_q, rt_q};
  assign fwd_rs = rs_data_q;
  assign fwd_rt = rt_data_q;
`endif

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign alu_a     = shamt_sel_q ? {27'b0, shamt_q} : fwd_rs;
  assign alu_b     = alusrc_q ? imm_q : fwd_rt;
  assign alu_fun   = fun_q;
  assign alu_sign  = sign_q;
  assign out_rd    = rd_q;
  assign out_pc    = pc_q;

  always_comb begin
    valid_d     = valid_q;
    fun_d       = fun_q;
    sign_d      = sign_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    shamt_d     = shamt_q;
    alusrc_d    = alusrc_q;
    shamt_sel_d = shamt_sel_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    pc_d        = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d     = 1'b1;
      fun_d       = dec_alufun;
      sign_d      = dec_sign;
      rs_data_d   = dec_rs_data;
      rt_data_d   = dec_rt_data;
      imm_d       = dec_imm;
      shamt_d     = dec_shamt;
      alusrc_d    = dec_alusrc;
      shamt_sel_d = dec_shamt_sel;
      rs_d        = dec_rs;
      rt_d        = dec_rt;
      rd_d        = dec_rd;
      pc_d        = dec_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
`ifdef ID_EX_FORWARD_EN
    end else if (valid_q) begin
      // Stalled: latch bypassed values so they survive their producer retiring.
      if (rs_hit) rs_data_d = fwd_rs;
      if (rt_hit) rt_data_d = fwd_rt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      fun_q       <= ALU_ADD;
      sign_q      <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      alusrc_q    <= 1'b0;
      shamt_sel_q <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
    end else begin
      valid_q     <= valid_d;
      fun_q       <= fun_d;
      sign_q      <= sign_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      alusrc_q    <= alusrc_d;
      shamt_sel_q <= shamt_sel_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: predictor queues accepted instructions, monitor checks ALU inputs.
module tb_id_ex_stage;
  import alu_pkg::*;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush;
  logic [5:0]  dec_alufun;
  logic        dec_sign, dec_alusrc, dec_shamt_sel;
  logic [31:0] dec_rs_data, dec_rt_data, dec_imm, dec_pc;
  logic [4:0]  dec_shamt, dec_rs, dec_rt, dec_rd;
  logic        exm_wr, wb_wr;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic        out_valid, out_ready, alu_sign;
  logic [31:0] alu_a, alu_b, out_pc;
  logic [5:0]  alu_fun;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .dec_alufun(dec_alufun), .dec_sign(dec_sign), .dec_rs_data(dec_rs_data),
    .dec_rt_data(dec_rt_data), .dec_imm(dec_imm), .dec_shamt(dec_shamt),
    .dec_alusrc(dec_alusrc), .dec_shamt_sel(dec_shamt_sel), .dec_rs(dec_rs),
    .dec_rt(dec_rt), .dec_rd(dec_rd), .dec_pc(dec_pc),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_fun(alu_fun), .alu_sign(alu_sign), .out_rd(out_rd), .out_pc(out_pc)
  );

  typedef struct {
    logic [5:0]  fun;
    logic        sign;
    logic [31:0] rs_data, rt_data, imm, pc;
    logic [4:0]  shamt, rs, rt, rd;
    logic        alusrc, shamt_sel;
  } instr_t;

  instr_t exp_q[$];
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Value a register operand resolves to given the live write-back buses.
  function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] d);
    logic [31:0] v;
    v = d;
    if (FWD && r != 5'd0) begin
      if (wb_wr && wb_rd == r)   v = wb_data;
      if (exm_wr && exm_rd == r) v = exm_data;
    end
    return v;
  endfunction

  // Predictor: decides at each edge what the stage holds afterwards.
  always @(posedge clk) begin
    instr_t e;
    if (reset || flush) begin
      exp_q.delete();
    end else if (in_valid && (exp_q.size() == 0 || out_ready)) begin
      e.fun = dec_alufun; e.sign = dec_sign; e.rs_data = dec_rs_data; e.rt_data = dec_rt_data;
      e.imm = dec_imm; e.pc = dec_pc; e.shamt = dec_shamt; e.rs = dec_rs; e.rt = dec_rt;
      e.rd = dec_rd; e.alusrc = dec_alusrc; e.shamt_sel = dec_shamt_sel;
      exp_q.push_back(e);
    end else if (exp_q.size() != 0 && !out_ready) begin
      if (!exp_q[0].shamt_sel) exp_q[0].rs_data = resolve(exp_q[0].rs, exp_q[0].rs_data);
      if (!exp_q[0].alusrc)    exp_q[0].rt_data = resolve(exp_q[0].rt, exp_q[0].rt_data);
    end
  end

  // Monitor: compares presented outputs against the queue head, pops on transfer out.
  always @(negedge clk) begin
    instr_t e;
    logic [31:0] ea, eb;
    if (mon_en && !reset) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0) || out_ready});
      if (exp_q.size() != 0) begin
        e  = exp_q[0];
        ea = e.shamt_sel ? {27'b0, e.shamt} : resolve(e.rs, e.rs_data);
        eb = e.alusrc ? e.imm : resolve(e.rt, e.rt_data);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_fun", {26'b0, alu_fun}, {26'b0, e.fun});
        chk("alu_sign", {31'b0, alu_sign}, {31'b0, e.sign});
        chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
        chk("out_pc", out_pc, e.pc);
        if (out_valid && out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    exm_wr = 1'b0; exm_rd = 5'd0; exm_data = 32'h0;
    wb_wr = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
  endtask

  task automatic set_instr(input logic [5:0] fun, input logic [4:0] rs, input logic [31:0] rsd,
                           input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                           input logic [31:0] pc);
    dec_alufun = fun; dec_sign = 1'b0; dec_rs = rs; dec_rs_data = rsd; dec_rt = rt;
    dec_rt_data = rtd; dec_rd = rd; dec_pc = pc; dec_imm = 32'h0; dec_shamt = 5'd0;
    dec_alusrc = 1'b0; dec_shamt_sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    bus_idle();
    set_instr(ALU_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    step(); step();
    reset = 1'b0;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_fun", {26'b0, alu_fun}, {26'b0, ALU_ADD});
    chk("rst_a", alu_a, 32'h0);
    chk("rst_b", alu_b, 32'h0);
    chk("rst_rd", {27'b0, out_rd}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    mon_en = 1'b1;

    // ADD r8=5, r9=7, then bypass priority while held.
    set_instr(ALU_ADD, 5'd8, 32'd5, 5'd9, 32'd7, 5'd10, 32'h100);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("add_valid", {31'b0, out_valid}, 32'h1);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    exm_wr = 1'b1; exm_rd = 5'd8; exm_data = 32'h11;
    wb_wr = 1'b1; wb_rd = 5'd8; wb_data = 32'h22;
    #1;
    chk("fwd_exm_prio", alu_a, FWD ? 32'h11 : 32'd5);
    exm_wr = 1'b0;
    #1;
    chk("fwd_wb", alu_a, FWD ? 32'h22 : 32'd5);
    out_ready = 1'b1;
    step();
    bus_idle();

    // r0 never forwards.
    set_instr(ALU_OR, 5'd0, 32'd3, 5'd0, 32'd3, 5'd1, 32'h104);
    exm_wr = 1'b1; exm_data = 32'hDEAD; wb_wr = 1'b1; wb_data = 32'hBEEF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    chk("r0_a", alu_a, 32'd3);
    bus_idle();

    // SRA with shamt operand, then a 3-cycle stall with a short-lived bypass on rt.
    set_instr(ALU_SRA, 5'd8, 32'h0, 5'd9, 32'h80000000, 5'd2, 32'h108);
    dec_shamt_sel = 1'b1; dec_shamt = 5'd4;
    in_valid = 1'b1;
    step();
    chk("sra_a", alu_a, 32'h4);
    chk("sra_b", alu_b, 32'h80000000);
    chk("sra_fun", {26'b0, alu_fun}, {26'b0, ALU_SRA});
    set_instr(ALU_SUB, 5'd3, 32'h33, 5'd4, 32'h44, 5'd5, 32'h200);
    out_ready = 1'b0;
    exm_wr = 1'b1; exm_rd = 5'd9; exm_data = 32'hAB;
    step();
    bus_idle();
    step(); step();
    chk("stall_b", alu_b, FWD ? 32'hAB : 32'h80000000);
    chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
    out_ready = 1'b1;
    step();
    chk("pending_pc", out_pc, 32'h200);

    // Back-to-back stream with a flush in the middle.
    for (int i = 0; i < 6; i++) begin
      set_instr(ALU_XOR, 5'd1, i, 5'd2, i + 1, 5'd3, 32'h300 + 4 * i);
      in_valid = 1'b1;
      flush = (i == 3);
      step();
      if (i == 3) chk("flush_valid", {31'b0, out_valid}, 32'h0);
      else        chk("stream_pc", out_pc, 32'h300 + 4 * i);
    end
    flush = 1'b0; in_valid = 1'b0;
    step();

    // Randomized traffic with tight register range to provoke bypass hits.
    for (int n = 0; n < 600; n++) begin
      dec_alufun = 6'($urandom); dec_sign = 1'($urandom);
      dec_rs = 5'($urandom_range(0, 3)); dec_rt = 5'($urandom_range(0, 3));
      dec_rd = 5'($urandom); dec_rs_data = $urandom; dec_rt_data = $urandom;
      dec_imm = $urandom; dec_shamt = 5'($urandom); dec_pc = $urandom;
      dec_alusrc = 1'($urandom); dec_shamt_sel = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) == 0);
      exm_wr = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_data = $urandom;
      wb_wr = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    bus_idle();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
